// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute control for the ALU; fetches via mem_*, drives instr/rf_* to the ALU and register file, keeps psr, pulses illegal
module alu_sequencer #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_valid,
  output logic [15:0]     instr,
  output logic [3:0]      rf_raddr_a,
  output logic [3:0]      rf_raddr_b,
  input  logic [4:0]      alu_flags,
  output logic            carry_in,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [4:0]      psr,
  output logic            illegal
);
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE} state_t;
  localparam logic [15:0] OP0_LEGAL = 16'h6EEE;
  localparam logic [15:0] SHIFT_LEGAL = 16'h005F;
  localparam logic [15:0] OP_LEGAL = 16'hEFEF;
  localparam logic [15:0] ARITH = 16'h06A0;
  state_t state;
  logic [PC_W-1:0] pc;
  logic [3:0] op, ext;
  logic legal, cmp, arith, exec;
  assign op = instr[15:12];
  assign ext = instr[7:4];
  assign legal = op == 4'h0 ? OP0_LEGAL[ext] : op == 4'h8 ? SHIFT_LEGAL[ext] : OP_LEGAL[op];
  assign cmp = legal && (op == 4'h0 ? ext == 4'hB : op == 4'hB);
  assign arith = legal && (op == 4'h0 ? ARITH[ext] : ARITH[op]);
  assign exec = state == EXECUTE && !reset;
  assign mem_req = state == FETCH && !reset;
  assign mem_addr = pc;
  assign rf_raddr_a = instr[11:8];
  assign rf_raddr_b = instr[3:0];
  assign rf_waddr = instr[11:8];
  assign carry_in = psr[3];
  assign rf_we = exec && legal && !cmp;
  assign illegal = exec && !legal;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= '0;
      instr <= '0;
      psr <= '0;
    end else if (state == FETCH) begin
      if (mem_valid) begin
        instr <= mem_rdata;
        state <= DECODE;
      end
    end else if (state == DECODE) begin
      state <= EXECUTE;
    end else begin
      pc <= pc + 1'b1;
      state <= FETCH;
      if (arith) psr[3:2] <= alu_flags[3:2];
      if (cmp) psr <= {alu_flags[4], psr[3:2], alu_flags[1:0]};
    end
  end
endmodule
